// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs data-memory accesses over a req/ack port,
// stalls upstream until each access completes, and feeds MEMWB_Pipe.
module mem_stage_ctrl #(
   parameter int ARQ     = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              wb_enable_in,
   input  logic              mem_rd_mux_in,
   input  logic              pc_en_in,
   input  logic [ARQ-1:0]    alu_result_in,
   input  logic [ARQ-1:0]    store_data_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [ARQ-1:0]    dmem_wdata,
   input  logic              dmem_ack,
   input  logic [ARQ-1:0]    dmem_rdata,
   output logic              stall,
   output logic              mem_rd_mux_out,
   output logic              wb_enable_out,
   output logic              pc_en_out,
   output logic [ARQ-1:0]    alu_result_out,
   output logic [ARQ-1:0]    mem_result_out,
   output logic              dmem_err
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ARQ-1:0]   data_q, data_d;
   logic             aborted_q, aborted_d;
   logic             err_q, err_d;
   logic             mem_op;

   assign mem_op = ex_valid & (mem_read_in | mem_write_in);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      aborted_d = aborted_q;
      err_d     = err_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (mem_op) begin
               state_d   = S_REQ;
               aborted_d = 1'b0;
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dmem_ack) begin
               state_d   = S_DONE;
               aborted_d = 1'b0;
               data_d    = mem_write_in ? '0 : dmem_rdata;
            end else if (cnt_q == CNT_LAST) begin
               // Memory never answered: drop the write-back, flag it.
               state_d   = S_DONE;
               aborted_d = 1'b1;
               data_d    = '0;
               err_d     = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         aborted_q <= aborted_d;
         err_q     <= err_d;
      end
   end

   // Reset forces every output low, independent of state and inputs.
   always_comb begin
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      dmem_addr      = '0;
      dmem_wdata     = '0;
      stall          = 1'b0;
      mem_rd_mux_out = 1'b0;
      wb_enable_out  = 1'b0;
      pc_en_out      = 1'b0;
      alu_result_out = '0;
      mem_result_out = '0;
      dmem_err       = 1'b0;
      if (!rst) begin
         mem_rd_mux_out = mem_rd_mux_in;
         pc_en_out      = pc_en_in;
         alu_result_out = alu_result_in;
         dmem_err       = err_q;
         unique case (state_q)
            S_IDLE: begin
               stall         = mem_op;
               wb_enable_out = wb_enable_in & ex_valid & ~mem_op;
            end
            S_REQ: begin
               stall      = 1'b1;
               dmem_req   = 1'b1;
               dmem_we    = mem_write_in;
               dmem_addr  = alu_result_in[ADDR_W-1:0];
               dmem_wdata = store_data_in;
            end
            S_DONE: begin
               wb_enable_out  = wb_enable_in & ~aborted_q;
               mem_result_out = data_q;
            end
            default: begin
               stall = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: reset, pass-through, load, store,
// timeout abort and reset during an outstanding request.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, mem_read_in, mem_write_in, wb_enable_in;
   logic        mem_rd_mux_in, pc_en_in;
   logic [15:0] alu_result_in, store_data_in;
   logic        dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic        stall, mem_rd_mux_out, wb_enable_out, pc_en_out;
   logic [15:0] alu_result_out, mem_result_out;
   logic        dmem_err;

   int checks = 0;
   int errors = 0;
   int stall_cnt;
   int req_cnt;

   mem_stage_ctrl #(.ARQ(16), .ADDR_W(16), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .wb_enable_in(wb_enable_in),
      .mem_rd_mux_in(mem_rd_mux_in), .pc_en_in(pc_en_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .mem_rd_mux_out(mem_rd_mux_out),
      .wb_enable_out(wb_enable_out), .pc_en_out(pc_en_out),
      .alu_result_out(alu_result_out), .mem_result_out(mem_result_out),
      .dmem_err(dmem_err)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %04h expected %04h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input logic rd, input logic wr,
                         input logic wb, input logic mux, input logic pc,
                         input logic [15:0] alu, input logic [15:0] sd);
      ex_valid      = v;
      mem_read_in   = rd;
      mem_write_in  = wr;
      wb_enable_in  = wb;
      mem_rd_mux_in = mux;
      pc_en_in      = pc;
      alu_result_in = alu;
      store_data_in = sd;
   endtask

   task automatic rand_inputs;
      ex_valid      = 1'($urandom);
      mem_read_in   = 1'($urandom);
      mem_write_in  = 1'($urandom);
      wb_enable_in  = 1'($urandom);
      mem_rd_mux_in = 1'($urandom);
      pc_en_in      = 1'($urandom);
      alu_result_in = 16'($urandom);
      store_data_in = 16'($urandom);
      dmem_ack      = 1'($urandom);
      dmem_rdata    = 16'($urandom);
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, ".req"}, dmem_req, 1'b0);
      chk1({tag, ".we"}, dmem_we, 1'b0);
      chk16({tag, ".addr"}, dmem_addr, 16'h0);
      chk16({tag, ".wdata"}, dmem_wdata, 16'h0);
      chk1({tag, ".stall"}, stall, 1'b0);
      chk1({tag, ".mux"}, mem_rd_mux_out, 1'b0);
      chk1({tag, ".wb"}, wb_enable_out, 1'b0);
      chk1({tag, ".pc"}, pc_en_out, 1'b0);
      chk16({tag, ".alu"}, alu_result_out, 16'h0);
      chk16({tag, ".memres"}, mem_result_out, 16'h0);
      chk1({tag, ".err"}, dmem_err, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      // Two reset cycles with random inputs: everything held low.
      rand_inputs();
      #1;
      chk_all_zero("rst0");
      next_cycle();
      rand_inputs();
      #1;
      chk_all_zero("rst1");
      next_cycle();

      // ALU op, same-cycle pass-through.
      rst = 1'b0;
      dmem_ack = 1'b0;
      dmem_rdata = 16'h0;
      set_op(1, 0, 0, 1, 0, 1, 16'h1234, 16'h0);
      #1;
      chk1("alu.wb", wb_enable_out, 1'b1);
      chk16("alu.res", alu_result_out, 16'h1234);
      chk1("alu.stall", stall, 1'b0);
      chk1("alu.req", dmem_req, 1'b0);
      chk1("alu.pc", pc_en_out, 1'b1);
      chk16("alu.memres", mem_result_out, 16'h0);
      chk1("alu.err", dmem_err, 1'b0);
      next_cycle();

      // Bubble: write-back suppressed.
      set_op(0, 0, 0, 1, 1, 0, 16'h5555, 16'h0);
      #1;
      chk1("bub.wb", wb_enable_out, 1'b0);
      chk1("bub.mux", mem_rd_mux_out, 1'b1);
      chk1("bub.stall", stall, 1'b0);
      next_cycle();

      // Load at 0x0040, ack in the third REQ cycle.
      stall_cnt = 0;
      set_op(1, 1, 0, 1, 1, 1, 16'h0040, 16'h0);
      #1;
      stall_cnt += int'(stall);
      chk1("ld.idle.wb", wb_enable_out, 1'b0);
      chk1("ld.idle.req", dmem_req, 1'b0);
      next_cycle();
      stall_cnt += int'(stall);
      chk1("ld.r1.req", dmem_req, 1'b1);
      chk1("ld.r1.we", dmem_we, 1'b0);
      chk16("ld.r1.addr", dmem_addr, 16'h0040);
      chk1("ld.r1.wb", wb_enable_out, 1'b0);
      next_cycle();
      stall_cnt += int'(stall);
      chk1("ld.r2.req", dmem_req, 1'b1);
      next_cycle();
      dmem_ack = 1'b1;
      dmem_rdata = 16'hBEEF;
      #1;
      stall_cnt += int'(stall);
      chk1("ld.r3.req", dmem_req, 1'b1);
      next_cycle();
      dmem_ack = 1'b0;
      dmem_rdata = 16'h0;
      #1;
      stall_cnt += int'(stall);
      chk1("ld.done.stall", stall, 1'b0);
      chk1("ld.done.req", dmem_req, 1'b0);
      chk16("ld.done.data", mem_result_out, 16'hBEEF);
      chk1("ld.done.wb", wb_enable_out, 1'b1);
      chk_int("ld.stall_cycles", stall_cnt, 4);
      next_cycle();

      // Store at 0x0010, ack in the first REQ cycle.
      stall_cnt = 0;
      set_op(1, 0, 1, 1, 0, 1, 16'h0010, 16'hA5A5);
      #1;
      stall_cnt += int'(stall);
      chk1("st.idle.stall", stall, 1'b1);
      next_cycle();
      dmem_ack = 1'b1;
      dmem_rdata = 16'h7777;
      #1;
      stall_cnt += int'(stall);
      chk1("st.r1.req", dmem_req, 1'b1);
      chk1("st.r1.we", dmem_we, 1'b1);
      chk16("st.r1.addr", dmem_addr, 16'h0010);
      chk16("st.r1.wdata", dmem_wdata, 16'hA5A5);
      next_cycle();
      dmem_ack = 1'b0;
      #1;
      stall_cnt += int'(stall);
      chk1("st.done.stall", stall, 1'b0);
      chk1("st.done.wb", wb_enable_out, 1'b1);
      chk16("st.done.data", mem_result_out, 16'h0);
      chk_int("st.stall_cycles", stall_cnt, 2);
      next_cycle();

      // Load with no ack: abort after 15 request cycles.
      stall_cnt = 0;
      req_cnt = 0;
      set_op(1, 1, 0, 1, 1, 1, 16'h0080, 16'h0);
      #1;
      stall_cnt += int'(stall);
      next_cycle();
      for (int i = 0; i < 15; i++) begin
         stall_cnt += int'(stall);
         req_cnt += int'(dmem_req);
         chk1("to.err_low", dmem_err, 1'b0);
         next_cycle();
      end
      stall_cnt += int'(stall);
      chk_int("to.req_cycles", req_cnt, 15);
      chk_int("to.stall_cycles", stall_cnt, 16);
      chk1("to.done.req", dmem_req, 1'b0);
      chk16("to.done.data", mem_result_out, 16'h0);
      chk1("to.done.wb", wb_enable_out, 1'b0);
      chk1("to.done.err", dmem_err, 1'b1);
      next_cycle();

      // Late ack in IDLE is ignored; error stays set.
      set_op(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      dmem_ack = 1'b1;
      dmem_rdata = 16'hFFFF;
      #1;
      chk1("late.req", dmem_req, 1'b0);
      chk1("late.stall", stall, 1'b0);
      chk1("late.err", dmem_err, 1'b1);
      next_cycle();
      dmem_ack = 1'b0;
      dmem_rdata = 16'h0;
      set_op(1, 0, 0, 1, 0, 0, 16'h4321, 16'h0);
      #1;
      chk1("late2.err", dmem_err, 1'b1);
      chk1("late2.wb", wb_enable_out, 1'b1);
      chk16("late2.memres", mem_result_out, 16'h0);
      next_cycle();

      // Reset in the second REQ cycle of a load.
      set_op(1, 1, 0, 1, 1, 1, 16'h0020, 16'h0);
      #1;
      next_cycle();
      chk1("rr.r1.req", dmem_req, 1'b1);
      next_cycle();
      rst = 1'b1;
      #1;
      chk1("rr.r2.req", dmem_req, 1'b0);
      chk1("rr.r2.stall", stall, 1'b0);
      next_cycle();
      rst = 1'b0;
      #1;
      chk1("rr.idle.req", dmem_req, 1'b0);
      chk1("rr.idle.stall", stall, 1'b1);
      chk1("rr.idle.err", dmem_err, 1'b0);
      next_cycle();
      dmem_ack = 1'b1;
      dmem_rdata = 16'h1357;
      #1;
      chk1("rr.r1b.req", dmem_req, 1'b1);
      chk16("rr.r1b.addr", dmem_addr, 16'h0020);
      next_cycle();
      dmem_ack = 1'b0;
      dmem_rdata = 16'h0;
      #1;
      chk16("rr.done.data", mem_result_out, 16'h1357);
      chk1("rr.done.wb", wb_enable_out, 1'b1);
      chk1("rr.done.stall", stall, 1'b0);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
